div_issue_queue: RTL and testbench

Request queue and issue sequencer that sits directly upstream of the serial fixed-point divider in the intersection datapath. It buffers up to DEPTH tagged dividend/divisor pairs and issues them one at a time to the divider's single-cycle `valid_in` strobe. It collects the quotient when `valid_out` rises and returns it over a ready/valid result port. Because the divider holds its result until it is reset, this block owns the divider's reset and clears it after every completed transaction.

---
 rtl/div_issue_queue.sv | 208 ++++++++++++++++++++
 tb/tb_div_issue_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_queue.sv
// div_issue_queue: queues tagged dividend/divisor pairs and feeds them one at a time to the serial divider.
// Latency: issue 1 cycle after accept; result DATA_WIDTH+3 cycles after accept (2 cycles for a zero-divisor bypass).
// Backpressure: in_ready is the registered not-full flag; a held result blocks issue until out_ready, then the divider is cleared.
// Optional feature macro: DIV_ZERO_BYPASS_EN (zero divisors are answered locally with a saturated quotient and out_dz=1).

// Generic circular FIFO with a registered not-full flag; a full FIFO refuses a push even if it pops in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push_fire;
  logic             pop_fire;

  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop && !empty;
  assign empty     = (count == '0);
  assign head_dat  = mem[rd_ptr];
  assign count_nxt = count + (AW+1)'(push_fire) - (AW+1)'(pop_fire);

  // Pointers, occupancy and the not-full flag, all cleared by reset so a reset flushes the queue.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_rdy <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      push_rdy <= (count_nxt != (AW+1)'(DEPTH));
    end
  end

  // Entry storage; never read while empty, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end
endmodule

module div_issue_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int QUANTIZED_BITS = 10,
  parameter int DEPTH          = 4,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  div_valid_in,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic                  div_valid_out,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  output logic                  div_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quotient,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_dz
);
  // The queue relies on power-of-two pointer wrap; the quotient format needs at least one integer bit.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || QUANTIZED_BITS >= DATA_WIDTH) begin : g_bad_cfg
    $error("div_issue_queue: DEPTH must be a power of two >= 2 and QUANTIZED_BITS < DATA_WIDTH");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_CLEAR
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t               state;
  req_t                 in_req;
  req_t                 head;
  logic                 q_empty;
  logic                 take;
  logic                 head_zero;
  logic                 issue;
  logic                 bypass;
  logic [TAG_WIDTH-1:0] pend_tag;

  assign in_req = {in_dividend, in_divisor, in_tag};

  sync_fifo #(
    .WIDTH($bits(req_t)),
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (in_req),
    .pop      (take),
    .empty    (q_empty),
    .head_dat (head)
  );

`ifdef DIV_ZERO_BYPASS_EN
  assign head_zero = (head.divisor == '0);
`else
  assign head_zero = 1'b0;
`endif

  // The head is consumed in the first IDLE cycle it is visible, so the issue strobe and operands are
  // decoded from registered state and the registered queue head rather than delayed another cycle.
  assign take         = (state == S_IDLE) && !q_empty;
  assign issue        = take && !head_zero;
  assign bypass       = take && head_zero;
  assign div_valid_in = issue;
  assign div_dividend = issue ? head.dividend : '0;
  assign div_divisor  = issue ? head.divisor  : '0;

  // Issue sequencer: one divide in flight, result held until accepted, divider cleared after every result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      pend_tag     <= '0;
      out_valid    <= 1'b0;
      out_quotient <= '0;
      out_tag      <= '0;
      div_clear    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          div_clear <= 1'b0;
          if (issue) begin
            pend_tag <= head.tag;
            state    <= S_WAIT;
          end else if (bypass) begin
            out_quotient <= head.dividend[DATA_WIDTH-1] ? SAT_NEG : SAT_POS;
            out_tag      <= head.tag;
            out_valid    <= 1'b1;
            state        <= S_HOLD;
          end
        end
        S_WAIT: begin
          if (div_valid_out) begin
            out_quotient <= div_quotient;
            out_tag      <= pend_tag;
            out_valid    <= 1'b1;
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            div_clear <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          div_clear <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  // Divide-by-zero flag travels with the held result: set by a bypass, cleared by a real completion.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_dz <= 1'b0;
    end else if (bypass) begin
      out_dz <= 1'b1;
    end else if (state == S_WAIT && div_valid_out) begin
      out_dz <= 1'b0;
    end
  end
`else
  assign out_dz = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_queue.sv
// tb_div_issue_queue: drives directed divide requests through div_issue_queue with a behavioural serial divider.
// Expected quotients, tags, flags and latencies are hand-computed per vector and queued when the request is accepted.
// A negedge monitor pops and compares each result, and watches div_clear pulses, hold stability and issue strobes.
module tb_div_issue_queue;
  localparam int DW    = 32;
  localparam int QB    = 10;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic [TW-1:0] in_tag;
  logic          div_valid_in;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic          div_valid_out;
  logic [DW-1:0] div_quotient;
  logic          div_clear;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quotient;
  logic [TW-1:0] out_tag;
  logic          out_dz;

  always #5 clock = ~clock;

  div_issue_queue #(
    .DATA_WIDTH(DW), .QUANTIZED_BITS(QB), .DEPTH(DEPTH), .TAG_WIDTH(TW)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid_out(div_valid_out), .div_quotient(div_quotient), .div_clear(div_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_tag(out_tag), .out_dz(out_dz)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fixed-point quotient of the behavioural divider; a zero divisor yields 0.
  function automatic logic [DW-1:0] fx_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [63:0] na, nb, r;
    na = {{32{a[DW-1]}}, a};
    nb = {{32{b[DW-1]}}, b};
    if (b == '0) return '0;
    r = (na <<< QB) / nb;
    return r[DW-1:0];
  endfunction

  // Behavioural serial divider: result valid DW+1 cycles after the issue strobe, held until cleared.
  logic          model_vo   = 1'b0;
  logic          model_busy = 1'b0;
  logic [DW-1:0] model_q    = '0;
  int            model_cnt  = 0;
  logic          stray      = 1'b0;

  always @(posedge clock) begin
    if (div_clear) begin
      model_busy <= 1'b0;
      model_vo   <= 1'b0;
      model_cnt  <= 0;
      model_q    <= '0;
    end else if (div_valid_in) begin
      model_busy <= 1'b1;
      model_vo   <= 1'b0;
      model_cnt  <= 1;
      model_q    <= fx_div(div_dividend, div_divisor);
    end else if (model_busy && !model_vo) begin
      if (model_cnt == DW) model_vo <= 1'b1;
      model_cnt <= model_cnt + 1;
    end
  end

  assign div_valid_out = model_vo | stray;
  assign div_quotient  = model_q;

  typedef struct {
    logic [DW-1:0] q;
    logic [TW-1:0] tag;
    logic          dz;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  int   cyc = 0;
  logic hs_edge = 1'b0;
  logic rst_edge = 1'b0;
  logic exp_clr;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    hs_edge  <= out_valid && out_ready;
    rst_edge <= reset;
  end

  assign exp_clr = hs_edge || !rst_edge;

  logic          prev_ov = 1'b0;
  logic          prev_vi = 1'b0;
  logic [DW-1:0] held_q  = '0;
  logic [TW-1:0] held_tag = '0;
  logic          held_dz = 1'b0;
  int            issue_count = 0;
  int            op_err = 0;

  // Monitor: scoreboard pop on each new result, hold stability, clear pulses and issue-strobe hygiene.
  always @(negedge clock) begin
    if (div_clear || exp_clr) chk("div_clear", 64'(div_clear), 64'(exp_clr));
    if (rst_edge) begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          chk("quotient", 64'(out_quotient), 64'(exp_q[0].q));
          chk("tag", 64'(out_tag), 64'(exp_q[0].tag));
          chk("dz", 64'(out_dz), 64'(exp_q[0].dz));
          if (exp_q[0].lat >= 0) chk("latency", 64'(cyc - acc_q[0]), 64'(exp_q[0].lat));
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        held_q   <= out_quotient;
        held_tag <= out_tag;
        held_dz  <= out_dz;
      end else if (out_valid && prev_ov) begin
        chk("hold_stable_quotient", 64'(out_quotient), 64'(held_q));
        chk("hold_stable_tag", 64'(out_tag), 64'(held_tag));
        chk("hold_stable_dz", 64'(out_dz), 64'(held_dz));
      end
    end
    if (div_valid_in) issue_count <= issue_count + 1;
    if ((div_valid_in && prev_vi) || (!div_valid_in && (div_dividend != '0 || div_divisor != '0)))
      op_err <= op_err + 1;
    prev_ov <= out_valid;
    prev_vi <= div_valid_in;
  end

  // Consumer: accepts immediately, or in backpressure mode only after 10 cycles of out_valid.
  logic bp_en = 1'b0;
  initial begin
    int ov_run;
    ov_run    = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (out_valid) ov_run++;
      else ov_run = 0;
      out_ready = !bp_en || (ov_run > 10);
    end
  end

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t,
                      input logic [DW-1:0] eq, input logic edz, input int lat, output int stall);
    exp_t e;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    stall       = 0;
    while (!in_ready && stall < 300) begin
      @(negedge clock);
      stall++;
    end
    if (!in_ready) begin
      chk("push_timeout", 64'(in_ready), 64'(1));
    end else begin
      e.q = eq; e.tag = t; e.dz = edz; e.lat = lat;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
    end
    @(negedge clock);
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || div_clear) && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (n >= 600) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int base;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_div_valid_in", 64'(div_valid_in), 64'(0));
    chk("rst_div_dividend", 64'(div_dividend), 64'(0));
    chk("rst_div_divisor", 64'(div_divisor), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_quotient", 64'(out_quotient), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_out_dz", 64'(out_dz), 64'(0));
    chk("rst_div_clear", 64'(div_clear), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Basic divide: 3.0 / 2.0 = 1.5
    base = issue_count;
    push(32'd3072, 32'd2048, 4'd5, 32'd1536, 1'b0, 35, st);
    wait_idle();
    chk("basic_issue_pulses", 64'(issue_count - base), 64'(1));

    // Fill and order, while tag 8 occupies the divider.
    base = issue_count;
    push(32'd10240, 32'd1024, 4'd8, 32'd10240, 1'b0, 35, st);
    push(32'd1024, 32'd1024, 4'd0, 32'd1024, 1'b0, -1, st);
    chk("fill_stall_tag0", 64'(st), 64'(0));
    push(32'hFFFFF800, 32'd1024, 4'd1, 32'hFFFFF800, 1'b0, -1, st);
    push(32'd5120, 32'd2048, 4'd2, 32'd2560, 1'b0, -1, st);
    push(32'd1024, 32'hFFFFFE00, 4'd3, 32'hFFFFF800, 1'b0, -1, st);
    chk("fill_stall_tag3", 64'(st), 64'(0));
    chk("fill_in_ready_low", 64'(in_ready), 64'(0));
    push(32'd7, 32'd3, 4'd4, 32'd2389, 1'b0, -1, st);
    chk("fill_tag4_stalled", 64'(st > 0), 64'(1));
    wait_idle();
    chk("fill_issue_pulses", 64'(issue_count - base), 64'(6));

    // Backpressure: 6.0 / 3.0 = 2.0 held for 10 cycles.
    bp_en = 1'b1;
    push(32'd6144, 32'd3072, 4'd6, 32'd2048, 1'b0, 35, st);
    wait_idle();
    bp_en = 1'b0;

    // Zero divisor.
    base = issue_count;
`ifdef DIV_ZERO_BYPASS_EN
    push(32'd100, 32'd0, 4'd2, 32'h7FFFFFFF, 1'b1, 2, st);
    wait_idle();
    push(32'hFFFFFFFB, 32'd0, 4'd3, 32'h80000000, 1'b1, 2, st);
    wait_idle();
    chk("dz_issue_pulses", 64'(issue_count - base), 64'(0));
`else
    push(32'd100, 32'd0, 4'd2, 32'd0, 1'b0, 35, st);
    wait_idle();
    push(32'hFFFFFFFB, 32'd0, 4'd3, 32'd0, 1'b0, 35, st);
    wait_idle();
    chk("dz_issue_pulses", 64'(issue_count - base), 64'(2));
`endif

    // Reset while in WAIT with two entries queued.
    push(32'd1024, 32'd1024, 4'd1, 32'd1024, 1'b0, 35, st);
    push(32'd2048, 32'd1024, 4'd2, 32'd2048, 1'b0, -1, st);
    push(32'd3072, 32'd1024, 4'd3, 32'd3072, 1'b0, -1, st);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clock);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_div_clear", 64'(div_clear), 64'(1));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b1;
    base = issue_count;
    repeat (6) @(negedge clock);
    chk("flush_no_issue", 64'(issue_count - base), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    push(32'd4096, 32'd2048, 4'd7, 32'd2048, 1'b0, 35, st);
    wait_idle();

    // Stray completion while idle and empty.
    base = issue_count;
    stray = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("stray_out_valid", 64'(out_valid), 64'(0));
    end
    stray = 1'b0;
    @(negedge clock);
    chk("stray_no_issue", 64'(issue_count - base), 64'(0));
    push(32'd2048, 32'd1024, 4'd3, 32'd2048, 1'b0, 35, st);
    wait_idle();

    chk("issue_strobe_hygiene", 64'(op_err), 64'(0));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
